// File: rtl/regfile_3port_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regfile_3port_pkg                                                          |
// | Shared sizes and CLEAR/RUN state encoding for the MIPS register file.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package regfile_3port_pkg;

  // Datapath-wide defaults, shared with the ALU and the datapath top
  localparam int REGBITS_DEF = 3;
  localparam int WIDTH_DEF   = 8;

  localparam logic S_CLEAR = 1'b0;
  localparam logic S_RUN   = 1'b1;

  typedef enum logic {
    ST_CLEAR = S_CLEAR,
    ST_RUN   = S_RUN
  } state_e;

  function automatic int nregs(input int regbits);
    return 1 << regbits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_clr_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regfile_clr_seq                                                            |
// | Post-reset clear sequencer: zeroes one entry per cycle, then raises ready. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module regfile_clr_seq
  import regfile_3port_pkg::*;
#(
  parameter int REGBITS = REGBITS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  output logic               clr_we,
  output logic [REGBITS-1:0] clr_addr,
  output logic               ready
);

  // NREGS is a power of two, so the last address is all ones
  localparam logic [REGBITS-1:0] CNT_LAST = '1;

  state_e             state_q, state_d;
  logic [REGBITS-1:0] cnt_q,   cnt_d;
  logic               ready_q, ready_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    if (reset) begin
      state_d = ST_CLEAR;
      cnt_d   = '0;
      ready_d = 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          // Leave CLEAR on the last address instead of letting cnt wrap
          if (cnt_q == CNT_LAST) begin
            state_d = ST_RUN;
            ready_d = 1'b1;
          end else begin
            cnt_d = cnt_q + REGBITS'(1);
          end
        end
        ST_RUN: begin
          state_d = ST_RUN;
        end
        default: begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          ready_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    ready_q <= ready_d;
  end

  assign clr_we   = (state_q == ST_CLEAR);
  assign clr_addr = cnt_q;
  assign ready    = ready_q;

endmodule
`default_nettype wire

// File: rtl/regfile_3port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regfile_3port                                                              |
// | 2-read / 1-write architectural register file with post-reset clearing.     |
// | Optional macro REGFILE_BYPASS_EN: write-through forwarding to read ports.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module regfile_3port
  import regfile_3port_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int REGBITS = REGBITS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [REGBITS-1:0] ra1,
  input  logic [REGBITS-1:0] ra2,
  input  logic               we3,
  input  logic [REGBITS-1:0] wa3,
  input  logic [WIDTH-1:0]   wd3,
  output logic [WIDTH-1:0]   rd1,
  output logic [WIDTH-1:0]   rd2,
  output logic               ready
);

  localparam int NREGS = nregs(REGBITS);

  logic               clr_we;
  logic [REGBITS-1:0] clr_addr;
  logic               run_we;

  logic [WIDTH-1:0] mem_q [NREGS];
  logic [WIDTH-1:0] mem_d [NREGS];

  regfile_clr_seq #(
    .REGBITS (REGBITS)
  ) u_clr_seq (
    .clk      (clk),
    .reset    (reset),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .ready    (ready)
  );

  // ready is high exactly when the sequencer is in RUN
  assign run_we = ready && we3 && (wa3 != '0);

  always_comb begin
    mem_d = mem_q;
    if (!reset) begin
      if (clr_we) begin
        mem_d[clr_addr] = '0;
      end else if (run_we) begin
        mem_d[wa3] = wd3;
      end
    end
    mem_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    rd1 = '0;
    if (ready && (ra1 != '0)) begin
      rd1 = mem_q[ra1];
`ifdef REGFILE_BYPASS_EN
      if (we3 && (wa3 == ra1)) begin
        rd1 = wd3;
      end
`endif
    end
  end

  always_comb begin
    rd2 = '0;
    if (ready && (ra2 != '0)) begin
      rd2 = mem_q[ra2];
`ifdef REGFILE_BYPASS_EN
      if (we3 && (wa3 == ra2)) begin
        rd2 = wd3;
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_3port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_regfile_3port                                                           |
// | Self-checking bench: directed vector table, corner sequences, random run.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_regfile_3port;

  localparam int WIDTH   = 8;
  localparam int REGBITS = 3;
  localparam int NREGS   = 8;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic [REGBITS-1:0] ra1, ra2, wa3;
  logic               we3;
  logic [WIDTH-1:0]   wd3;
  logic [WIDTH-1:0]   rd1, rd2;
  logic               ready;

  regfile_3port #(
    .WIDTH   (WIDTH),
    .REGBITS (REGBITS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .ra1   (ra1),
    .ra2   (ra2),
    .we3   (we3),
    .wa3   (wa3),
    .wd3   (wd3),
    .rd1   (rd1),
    .rd2   (rd2),
    .ready (ready)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: architectural contents plus edges since the clear began
  int mem_m [NREGS];
  bit ready_m    = 1'b0;
  bit clearing_m = 1'b0;
  int clr_n      = 0;

  typedef struct {
    bit we;
    int wa;
    int wd;
    int ra1;
    int ra2;
    int e1;
    int e2;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_rd(input int ra);
    if (!ready_m || ra == 0) return 0;
    if (BYP && we3 && (int'(wa3) == ra)) return int'(wd3);
    return mem_m[ra];
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      clearing_m = 1'b1;
      clr_n      = 0;
      ready_m    = 1'b0;
    end else if (clearing_m) begin
      clr_n++;
      if (clr_n == NREGS) begin
        clearing_m = 1'b0;
        ready_m    = 1'b1;
        for (int i = 0; i < NREGS; i++) mem_m[i] = 0;
      end
    end else if (we3 && wa3 != '0) begin
      mem_m[wa3] = int'(wd3);
    end
    #1;
  endtask

  task automatic drive(input bit we, input int wa, input int wd, input int a1, input int a2);
    we3 = we;
    wa3 = REGBITS'(wa);
    wd3 = WIDTH'(wd);
    ra1 = REGBITS'(a1);
    ra2 = REGBITS'(a2);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_rd1"},   {24'd0, rd1}, exp_rd(int'(ra1)));
    check({tag, "_rd2"},   {24'd0, rd2}, exp_rd(int'(ra2)));
    check({tag, "_ready"}, {31'd0, ready}, {31'd0, ready_m});
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) mem_m[i] = 0;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);

    // Clear sequence after a 2-cycle reset, with a write attempted mid-clear
    tick();
    check("reset_ready0", {31'd0, ready}, 0);
    tick();
    check("reset_ready1", {31'd0, ready}, 0);
    reset = 1'b0;
    for (int k = 1; k <= NREGS; k++) begin
      drive(k == 4, 4, 8'h77, int'($urandom_range(1, 7)), int'($urandom_range(1, 7)));
      check("clear_rd1", {24'd0, rd1}, 0);
      check("clear_rd2", {24'd0, rd2}, 0);
      tick();
      check("clear_ready", {31'd0, ready}, (k == NREGS) ? 1 : 0);
    end
    for (int a = 0; a < NREGS; a++) begin
      drive(0, 0, 0, a, NREGS - 1 - a);
      check("post_clear_rd1", {24'd0, rd1}, 0);
      check("post_clear_rd2", {24'd0, rd2}, 0);
    end

    // Directed vectors; expected values are the reads seen before the edge
    vecs[0] = '{1'b1, 5, 'hA5, 0, 0, 'h00, 'h00};
    vecs[1] = '{1'b0, 0, 'h00, 5, 0, 'hA5, 'h00};
    vecs[2] = '{1'b1, 0, 'hFF, 0, 5, 'h00, 'hA5};
    vecs[3] = '{1'b0, 0, 'h00, 0, 1, 'h00, 'h00};
    vecs[4] = '{1'b1, 3, 'h11, 5, 3, 'hA5, BYP ? 'h11 : 'h00};
    vecs[5] = '{1'b1, 3, 'h22, 3, 3, BYP ? 'h22 : 'h11, BYP ? 'h22 : 'h11};
    vecs[6] = '{1'b0, 0, 'h00, 3, 3, 'h22, 'h22};
    vecs[7] = '{1'b1, 7, 'h5C, 7, 5, BYP ? 'h5C : 'h00, 'hA5};
    vecs[8] = '{1'b0, 0, 'h00, 7, 6, 'h5C, 'h00};
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra1, vecs[i].ra2);
      check($sformatf("vec%0d_rd1", i), {24'd0, rd1}, vecs[i].e1);
      check($sformatf("vec%0d_rd2", i), {24'd0, rd2}, vecs[i].e2);
      check_model($sformatf("vec%0d_model", i));
      tick();
    end

    // Randomized traffic, occasional resets, reads biased toward the write address
    for (int n = 0; n < 400; n++) begin
      int wa;
      wa = int'($urandom_range(0, NREGS - 1));
      reset = ($urandom_range(0, 59) == 0);
      drive($urandom_range(0, 1) == 1, wa, int'($urandom_range(0, 255)),
            ($urandom_range(0, 2) == 0) ? wa : int'($urandom_range(0, NREGS - 1)),
            ($urandom_range(0, 2) == 0) ? wa : int'($urandom_range(0, NREGS - 1)));
      check_model("rand");
      tick();
    end
    reset = 1'b0;

    // Reset while the clear count sits at 5
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("midclr_pre_ready", {31'd0, ready}, 0);
    end
    reset = 1'b1;
    tick();
    check("midclr_reset_ready", {31'd0, ready}, 0);
    reset = 1'b0;
    for (int k = 1; k <= NREGS; k++) begin
      tick();
      check("midclr_restart_ready", {31'd0, ready}, (k == NREGS) ? 1 : 0);
    end

    // Reset in RUN coinciding with a write to register 2
    drive(1, 2, 'h39, 0, 0);
    tick();
    drive(0, 0, 0, 2, 0);
    check("run_pre_reset_rd1", {24'd0, rd1}, 'h39);
    reset = 1'b1;
    drive(1, 2, 'h66, 2, 2);
    tick();
    check("run_reset_ready", {31'd0, ready}, 0);
    reset = 1'b0;
    drive(0, 0, 0, 2, 2);
    begin
      int waited;
      waited = 0;
      while (!ready && waited < 20) begin
        tick();
        waited++;
      end
      check("run_reset_ready_seen", {31'd0, ready}, 1);
      check("run_reset_latency", waited, NREGS);
    end
    drive(0, 0, 0, 2, 2);
    check("run_reset_mem2_rd1", {24'd0, rd1}, 0);
    check_model("run_reset_model");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
